// File: rtl/wave_decimator_pkg.sv
// ============================================================================
//  Module : wave_decimator_pkg
//  Brief  : Shared state codes, AD mid-scale and width defaults for the
//           wave decimator, the AD wrapper and the command processor.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package wave_decimator_pkg;

    localparam int          DW_DEF     = 8;
    localparam int          RATE_W_DEF = 3;
    localparam int          CNT_W_DEF  = 16;
    localparam logic [7:0]  AD_MID     = 8'd128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Distance of an offset-binary sample from mid-scale; 128 still fits in 8 bits.
    function automatic logic [DW_DEF-1:0] abs_dev(input logic [DW_DEF-1:0] x);
        return (x >= AD_MID) ? (x - AD_MID) : (AD_MID - x);
    endfunction

endpackage

`default_nettype wire

// File: rtl/wave_decimator_group_reduce.sv
// ============================================================================
//  Module : wave_decimator_group_reduce
//  Brief  : Reduces a group of AD samples to one value: truncating mean, or
//           the largest-excursion sample when PEAK_DETECT_EN is defined.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module wave_decimator_group_reduce
    import wave_decimator_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int RATE_W = RATE_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_accept,
    input  logic              i_last,
    input  logic [RATE_W-1:0] i_rate,
    input  logic [DW-1:0]     i_sample,
    output logic [DW-1:0]     o_result
);

    // o_result already includes i_sample, so the closing sample is reduced in the
    // same cycle it is accepted and the state can restart empty for the next group.
`ifdef PEAK_DETECT_EN
    logic [DW-1:0] peak_q, peak_d;
    logic          have_q, have_d;
    logic          take;
    logic [RATE_W-1:0] unused_rate;

    assign unused_rate = i_rate;

    always_comb begin
        peak_d   = peak_q;
        have_d   = have_q;
        // Strictly greater: on a tie the earlier sample is kept.
        take     = !have_q || (abs_dev(DW_DEF'(i_sample)) > abs_dev(DW_DEF'(peak_q)));
        o_result = take ? i_sample : peak_q;
        if (i_clear) begin
            have_d = 1'b0;
        end else if (i_accept) begin
            have_d = !i_last;
            peak_d = o_result;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            peak_q <= '0;
            have_q <= 1'b0;
        end else begin
            peak_q <= peak_d;
            have_q <= have_d;
        end
    end
`else
    localparam int ACC_W = DW + (1 << RATE_W) - 1;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] sum_next;
    logic [ACC_W-1:0] shifted;

    always_comb begin
        acc_d    = acc_q;
        sum_next = acc_q + ACC_W'(i_sample);
        shifted  = sum_next >> i_rate;
        o_result = shifted[DW-1:0];
        if (i_clear) begin
            acc_d = '0;
        end else if (i_accept) begin
            acc_d = i_last ? '0 : sum_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/wave_decimator.sv
// ============================================================================
//  Module : wave_decimator
//  Brief  : Decimates AD samples by 2^rate into i_count output samples per
//           acquisition. Define PEAK_DETECT_EN for peak instead of mean.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module wave_decimator
    import wave_decimator_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int RATE_W = RATE_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [RATE_W-1:0] i_rate,
    input  logic [CNT_W-1:0]  i_count,
    input  logic [DW-1:0]     i_ad_data,
    input  logic              i_ad_valid,
    input  logic              i_full,
    output logic [DW-1:0]     o_data,
    output logic              o_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overflow
);

    localparam int GRP_W = (1 << RATE_W) - 1;

    state_t            state_q, state_d;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  smp_cnt_q, smp_cnt_d;
    logic [GRP_W-1:0]  grp_cnt_q, grp_cnt_d;
    logic [DW-1:0]     data_q, data_d;
    logic              pend_q, pend_d;
    logic              overflow_q, overflow_d;

    logic              start_ok;
    logic              accept;
    logic              close;
    logic [GRP_W-1:0]  grp_mask;
    logic [DW-1:0]     red_result;

    wave_decimator_group_reduce #(
        .DW     (DW),
        .RATE_W (RATE_W)
    ) u_reduce (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (start_ok),
        .i_accept (accept),
        .i_last   (close),
        .i_rate   (rate_q),
        .i_sample (i_ad_data),
        .o_result (red_result)
    );

    always_comb begin
        state_d    = state_q;
        rate_d     = rate_q;
        count_d    = count_q;
        smp_cnt_d  = smp_cnt_q;
        grp_cnt_d  = grp_cnt_q;
        data_d     = data_q;
        overflow_d = overflow_q;

        start_ok = (state_q == ST_IDLE) && i_start;
        grp_mask = GRP_W'((1 << rate_q) - 1);
        // Once every group of the acquisition has closed, further samples are ignored.
        accept   = (state_q == ST_ACQ) && i_ad_valid && (smp_cnt_q != count_q);
        close    = accept && (grp_cnt_q == grp_mask);
        pend_d   = close;

        if (accept) begin
            grp_cnt_d = close ? '0 : grp_cnt_q + GRP_W'(1);
        end
        if (close) begin
            data_d    = red_result;
            smp_cnt_d = smp_cnt_q + CNT_W'(1);
        end
        if (pend_q && i_full) begin
            overflow_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    rate_d     = i_rate;
                    count_d    = i_count;
                    smp_cnt_d  = '0;
                    grp_cnt_d  = '0;
                    overflow_d = 1'b0;
                    state_d    = (i_count == '0) ? ST_DONE : ST_ACQ;
                end
            end
            ST_ACQ: begin
                // Leave only after the final sample has been presented downstream.
                if (pend_q && (smp_cnt_q == count_q)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            rate_q     <= '0;
            count_q    <= '0;
            smp_cnt_q  <= '0;
            grp_cnt_q  <= '0;
            data_q     <= '0;
            pend_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rate_q     <= rate_d;
            count_q    <= count_d;
            smp_cnt_q  <= smp_cnt_d;
            grp_cnt_q  <= grp_cnt_d;
            data_q     <= data_d;
            pend_q     <= pend_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_data     = data_q;
    assign o_valid    = pend_q && !i_full;
    assign o_busy     = (state_q == ST_ACQ);
    assign o_done     = (state_q == ST_DONE);
    assign o_overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_wave_decimator.sv
// ============================================================================
//  Module : tb_wave_decimator
//  Brief  : Scoreboard bench for wave_decimator with a queue-based group model.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_wave_decimator;

    typedef struct {
        int data;
        int cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic [2:0]  i_rate;
    logic [15:0] i_count;
    logic [7:0]  i_ad_data;
    logic        i_ad_valid;
    logic        i_full;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        o_busy;
    logic        o_done;
    logic        o_overflow;

    int   checks   = 0;
    int   errors   = 0;
    int   cyc_g    = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];
    int   fixed_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_g++;

    wave_decimator dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (i_start),
        .i_rate     (i_rate),
        .i_count    (i_count),
        .i_ad_data  (i_ad_data),
        .i_ad_valid (i_ad_valid),
        .i_full     (i_full),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_overflow (o_overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int dev(input int x);
        return (x >= 128) ? x - 128 : 128 - x;
    endfunction

    // Expected group result straight from the sample list.
    function automatic int reduce(input int g[$], input int rate);
`ifdef PEAK_DETECT_EN
        int best = g[0];
        foreach (g[i]) if (dev(g[i]) > dev(best)) best = g[i];
        return best;
`else
        int sum = 0;
        foreach (g[i]) sum += g[i];
        return sum / (1 << rate);
`endif
    endfunction

    // Monitor: every strobe must match the oldest expected value and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (o_done) done_cnt++;
        if (o_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("o_data", o_data, e.data);
                chk("o_valid_cycle", cyc_g, e.cyc);
            end
        end
    end

    // full_slot: -1 never full, -2 random full, k>=0 full during output slot k.
    task automatic run_acq(input int rate, input int count, input int full_slot,
                           input bit junk, input int abort);
        int need, closed, slot_val, slot_idx, accepted, cyc, budget, d0, s;
        int grp[$];
        bit slot, ovf, v, f;
        need = 1 << rate; closed = 0; slot = 0; slot_idx = 0;
        ovf = 0; accepted = 0; cyc = 0; slot_val = 0;
        budget = 40 + 4 * need * count;

        @(posedge clk); #1;
        i_start = 1; i_rate = 3'(rate); i_count = 16'(count);
        i_ad_valid = 0; i_full = 0;
        @(posedge clk); #1;
        i_start = 0;
        if (count == 0) begin
            @(negedge clk);
            chk("zero_done", o_done, 1);
            chk("zero_busy", o_busy, 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("zero_done_pulse", o_done, 0);
            return;
        end

        while (closed < count || slot) begin
            if (cyc > budget) begin
                chk("acq_timeout", cyc, budget);
                break;
            end
            if (fixed_q.size() > 0) begin
                v = 1; s = fixed_q.pop_front();
            end else begin
                v = ($urandom_range(0, 9) < 7); s = $urandom_range(0, 255);
            end
            if (full_slot == -2) f = ($urandom_range(0, 3) == 0);
            else                 f = slot && (slot_idx == full_slot);
            i_ad_valid = v; i_ad_data = 8'(s); i_full = f;
            i_start = junk && (cyc == 3);
            i_rate  = 3'($urandom_range(0, 7));
            i_count = 16'($urandom_range(1, 65535));

            if (slot) begin
                if (f) ovf = 1;
                else   exp_q.push_back('{data: slot_val, cyc: cyc_g});
                slot = 0; slot_idx++;
            end
            if (v && closed < count) begin
                accepted++;
                grp.push_back(s);
                if (grp.size() == need) begin
                    slot_val = reduce(grp, rate);
                    grp.delete();
                    closed++;
                    slot = 1;
                end
            end
            @(negedge clk);
            if (cyc == 0) begin
                chk("busy_in_acq", o_busy, 1);
                chk("overflow_cleared", o_overflow, 0);
            end
            if (abort > 0 && accepted == abort) break;
            @(posedge clk); #1;
            cyc++;
        end

        i_start = 0; i_ad_valid = 0; i_full = 0;
        if (abort > 0) begin
            d0 = done_cnt;
            #2 rst_n = 0;
            #1 chk("reset_outputs", {o_valid, o_busy, o_done, o_overflow, o_data}, 0);
            repeat (3) @(posedge clk);
            @(negedge clk);
            rst_n = 1;
            @(negedge clk);
            chk("reset_no_done", done_cnt, d0);
            chk("reset_idle", {o_busy, o_done, o_valid}, 0);
            chk("queue_empty_reset", exp_q.size(), 0);
            return;
        end

        @(negedge clk);
        chk("done_pulse", o_done, 1);
        chk("busy_after", o_busy, 0);
        chk("overflow", o_overflow, ovf);
        @(posedge clk); #1;
        @(negedge clk);
        chk("done_one_cycle", o_done, 0);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r, c;
        i_start = 0; i_rate = 0; i_count = 0;
        i_ad_data = 0; i_ad_valid = 0; i_full = 0;
        rst_n = 1;
        #1 rst_n = 0;
        #1 chk("reset_state", {o_valid, o_busy, o_done, o_overflow, o_data}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;

        fixed_q = '{10, 11, 12, 13};
        run_acq(0, 4, -1, 0, 0);
        fixed_q = '{0, 4, 8, 12, 100, 100, 100, 103};
        run_acq(2, 2, -1, 0, 0);
        run_acq(0, 0, -1, 0, 0);
        fixed_q = '{1, 3, 5, 7, 9, 11};
        run_acq(1, 3, 1, 0, 0);
        fixed_q = '{200, 10, 50, 60, 70, 80, 90, 100, 110, 120, 130, 140};
        run_acq(2, 3, -1, 1, 0);
        fixed_q = '{5, 6, 7, 8, 9};
        run_acq(1, 10, -1, 0, 5);
        fixed_q = '{30, 31, 32, 33};
        run_acq(1, 2, -1, 0, 0);
        fixed_q = '{130, 20, 236, 128};
        run_acq(2, 1, -1, 0, 0);
        fixed_q = '{255, 0};
        run_acq(1, 1, -1, 0, 0);
        for (int i = 0; i < 128; i++) fixed_q.push_back(255);
        run_acq(7, 1, -1, 0, 0);

        for (int i = 0; i < 12; i++) begin
            r = $urandom_range(0, 7);
            c = $urandom_range(1, (r > 4) ? 2 : 6);
            run_acq(r, c, ($urandom_range(0, 1) == 1) ? -2 : -1, 1'($urandom_range(0, 1)), 0);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
